// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter sharing the register-file write port among four requesters.
// Registered write stage plus a saturating committed-write counter.
module regwrite_arbiter #(
  parameter int width       = 32,
  parameter int addr_width  = 5,
  parameter int count_width = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req_valid,
  input  logic [4*addr_width-1:0] req_addr,
  input  logic [4*width-1:0]      req_data,
  output logic [3:0]              req_ready,
  input  logic                    hold,
  output logic                    wr_enable,
  output logic [addr_width-1:0]   wr_addr,
  output logic [width-1:0]        wr_data,
  output logic [1:0]              grant_id,
  output logic [count_width-1:0]  write_count
);

  logic [1:0]             ptr_q, ptr_d;
  logic                   en_q, en_d;
  logic [addr_width-1:0]  addr_q, addr_d;
  logic [width-1:0]       data_q, data_d;
  logic [1:0]             gid_q, gid_d;
  logic [count_width-1:0] cnt_q, cnt_d;

  logic                  win_found;
  logic [1:0]            win_idx;
  logic                  xfer;
  logic [addr_width-1:0] sel_addr;
  logic [width-1:0]      sel_data;

  // Scan downwards so the requester closest to ptr is assigned last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  assign xfer      = !hold && win_found;
  assign req_ready = xfer ? (4'b0001 << win_idx) : 4'b0000;
  assign sel_addr  = req_addr[int'(win_idx)*addr_width +: addr_width];
  assign sel_data  = req_data[int'(win_idx)*width +: width];

  always_comb begin
    ptr_d  = ptr_q;
    en_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      ptr_d  = win_idx + 2'd1;
      en_d   = (sel_addr != '0);
      addr_d = sel_addr;
      data_d = sel_data;
      gid_d  = win_idx;
      // Register 0 writes are consumed but never counted.
      if ((sel_addr != '0) && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q  <= gid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wr_enable   = en_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign grant_id    = gid_q;
  assign write_count = cnt_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: directed scenarios then random traffic,
// checked against a queue of expected write-port states from a reference model.
module tb_regwrite_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      req_valid = '0;
  logic [4*AW-1:0] req_addr = '0;
  logic [4*DW-1:0] req_data = '0;
  logic [3:0]      req_ready;
  logic            hold = 1'b0;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [1:0]      grant_id;
  logic [CW-1:0]   write_count;

  regwrite_arbiter #(
    .width(DW), .addr_width(AW), .count_width(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .hold(hold),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_id(grant_id), .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    gid;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   have_pend = 0;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int            m_ptr = 0;
  logic [CW-1:0] m_cnt = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [1:0]    m_gid = '0;
  bit            last_xfer;
  int            last_win;

  logic [AW-1:0] ra[4];
  logic [DW-1:0] rd[4];
  logic [3:0]    rv;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (wr_enable !== e.en || wr_addr !== e.addr || wr_data !== e.data ||
            grant_id !== e.gid || write_count !== e.cnt) begin
          failures++;
          $display("FAIL wr_port got en=%0b addr=%0d data=%h gid=%0d cnt=%0d expected en=%0b addr=%0d data=%h gid=%0d cnt=%0d",
                   wr_enable, wr_addr, wr_data, grant_id, write_count,
                   e.en, e.addr, e.data, e.gid, e.cnt);
        end
      end
    end
  end

  task automatic cycle(input logic [3:0] v, input logic h);
    int w;
    logic [3:0] er;
    bit xf;
    bit en;
    @(posedge clk);
    if (have_pend) begin
      q.push_back(pend);
      have_pend = 0;
    end
    #1;
    req_valid = v;
    hold = h;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
    #1;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (w < 0 && v[j]) w = j;
    end
    xf = !h && (w >= 0);
    er = xf ? 4'(1 << w) : 4'b0000;
    chk("req_ready", {28'd0, req_ready}, {28'd0, er});
    en = 0;
    if (xf) begin
      m_addr = ra[w];
      m_data = rd[w];
      m_gid  = 2'(w);
      en     = (ra[w] != 0);
      m_ptr  = (w + 1) % 4;
      if (en && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
    end
    pend.en   = en;
    pend.addr = m_addr;
    pend.data = m_data;
    pend.gid  = m_gid;
    pend.cnt  = m_cnt;
    have_pend = 1;
    last_xfer = xf;
    last_win  = w;
  endtask

  // Async reset asserted between edges; optionally checks an in-flight write first.
  task automatic do_reset(input bit check_en);
    @(posedge clk);
    q.delete();
    have_pend = 0;
    #3;
    if (check_en) chk("pre_reset_wr_enable", {31'd0, wr_enable}, 32'd1);
    reset = 1'b1;
    req_valid = '0;
    hold = 1'b0;
    #1;
    chk("rst_wr_enable", {31'd0, wr_enable}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_write_count", {28'd0, write_count}, 32'd0);
    m_ptr = 0; m_cnt = '0; m_addr = '0; m_data = '0; m_gid = '0;
    #3;
    reset = 1'b0;
  endtask

  task automatic flush();
    cycle(4'b0000, 1'b0);
    @(posedge clk);
    if (have_pend) begin
      q.push_back(pend);
      have_pend = 0;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end

    do_reset(0);

    // Single request from requester 2
    ra[2] = 5'd7; rd[2] = 32'hDEADBEEF;
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // Round-robin rotation from ptr 0
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      ra[i] = 5'(i + 1);
      rd[i] = 32'hA0 + i;
    end
    repeat (8) cycle(4'b1111, 1'b0);
    cycle(4'b0000, 1'b0);

    // Register 0 write then ptr check
    ra[1] = 5'd0; rd[1] = 32'd5;
    cycle(4'b0010, 1'b0);
    ra[0] = 5'd12; rd[0] = 32'h1234;
    ra[1] = 5'd13; rd[1] = 32'h5678;
    cycle(4'b0011, 1'b0);
    cycle(4'b0000, 1'b0);

    // Hold blocks acceptance
    ra[0] = 5'd20; rd[0] = 32'hCAFE0001;
    repeat (3) cycle(4'b0001, 1'b1);
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);

    // Reset discards an in-flight write
    ra[3] = 5'd9; rd[3] = 32'h99;
    cycle(4'b1000, 1'b0);
    do_reset(1);
    ra[1] = 5'd17; ra[3] = 5'd18;
    cycle(4'b1010, 1'b0);
    cycle(4'b0000, 1'b0);

    // Counter saturation at 15
    do_reset(0);
    for (int i = 0; i < 4; i++) ra[i] = 5'(i + 3);
    for (int n = 0; n < 17; n++) begin
      for (int i = 0; i < 4; i++) rd[i] = $urandom;
      cycle(4'b1111, 1'b0);
    end
    cycle(4'b0000, 1'b0);
    @(negedge clk);
    #1;
    chk("saturated_count", {28'd0, write_count}, 32'd15);

    // Random traffic with stable-until-accepted requesters
    rv = '0;
    for (int n = 0; n < 300; n++) begin
      logic h;
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          ra[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          rd[i] = $urandom;
        end
      end
      h = ($urandom_range(0, 4) == 0);
      cycle(rv, h);
      if (last_xfer) rv[last_win] = 1'b0;
      if (n == 150) do_reset(0);
    end

    flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Shares the single register-file write port among four requesters: ALU writeback, load unit, multiply/divide unit, and CP0/debug.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered output stage that drives the register file's write enable, address and data.
- Sits between the execution units and the register file. Also keeps a saturating count of committed writes for debug.

Parameters:
- width, 32, data width of the register file
- addr_width, 5, register index width
- count_width, 16, width of the committed-write counter

Ports:
- clk  input  1  clock, positive-edge
- reset  input  1  asynchronous reset, active-high
- req_valid  input  4  bit i: requester i has a write pending
- req_addr  input  4*addr_width  requester i address in bits [i*addr_width +: addr_width]
- req_data  input  4*width  requester i data in bits [i*width +: width]
- req_ready  output  4  bit i: requester i's write is accepted this cycle (combinational)
- hold  input  1  freeze the arbiter; no acceptance while high
- wr_enable  output  1  register-file write enable (registered)
- wr_addr  output  addr_width  register-file write address (registered)
- wr_data  output  width  register-file write data (registered)
- grant_id  output  2  index of the requester whose write is on the wr_* outputs (registered)
- write_count  output  count_width  number of committed writes, saturating

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, independent of clk. It clears:
  - wr_enable=0, wr_addr=0, wr_data=0, grant_id=0
  - write_count=0
  - round-robin pointer ptr=0
- A reset mid-operation discards any in-flight accepted write; that write is not retried.
- Winner selection (combinational):
  - Scan i = ptr, ptr+1, ptr+2, ptr+3 (mod 4). The winner is the first i with req_valid[i]=1.
  - If no requester is valid, there is no winner.
- req_ready[i] = (hold==0) && winner exists && winner==i.
  - At most one bit is high, and only for a valid requester.
  - req_ready never depends on wr_* state.
- Transfer occurs when req_valid[i] && req_ready[i]. On that clock edge:
  - wr_addr <= req_addr[i], wr_data <= req_data[i], grant_id <= i
  - wr_enable <= 1 if req_addr[i] != 0, else 0. A write to register 0 is accepted and consumed but never asserted to the register file.
  - ptr <= (i+1) mod 4
  - write_count increments if the new wr_enable=1. It saturates at all-ones.
- Latency: exactly 1 cycle from the acceptance edge to wr_enable/wr_addr/wr_data being valid. wr_enable is a 1-cycle pulse per accepted write.
- With no transfer (no valid requester, or hold=1):
  - wr_enable <= 0
  - wr_addr, wr_data and grant_id hold their previous values
  - ptr and write_count are unchanged
- hold=1 blocks acceptance only. A write accepted on the previous edge still appears on the outputs during the hold cycle.
- Requesters must keep req_valid, req_addr and req_data stable until they see req_ready. The arbiter does not latch unaccepted requests.
- Two requesters targeting the same address in the same cycle: only the winner is accepted; the other waits. Ordering across requesters is arbitration order only.
- Fairness: a continuously valid requester is accepted within 4 non-hold cycles.
- ptr wraps from 3 to 0.
- write_count saturation: when write_count equals 2^count_width-1 it stays there.

Test Plan:
- Reset, then a single request: assert reset asynchronously between clock edges -> wr_enable, wr_addr, wr_data, grant_id and write_count read 0 immediately. Then req_valid=4'b0100, req_addr[2]=7, req_data[2]=32'hDEADBEEF -> req_ready=4'b0100 that cycle; next cycle wr_enable=1, wr_addr=7, wr_data=DEADBEEF, grant_id=2, write_count=1; following cycle wr_enable=0.
- Round-robin rotation: req_valid=4'b1111 held for 8 cycles, addresses 1..4 -> grants 0,1,2,3,0,1,2,3; one wr_enable pulse per cycle; write_count=8.
- Register 0 write: requester 1 writes addr 0, data 5 -> req_ready[1]=1; next cycle wr_enable=0, grant_id=1; write_count unchanged; ptr advances to 2. Verify by then driving req_valid=4'b0011 -> requester 0 wins.
- Hold: req_valid=4'b0001 with hold=1 for 3 cycles -> req_ready=0 and wr_enable=0 throughout; release hold -> accepted on the first cycle, wr_enable=1 on the next.
- Reset mid-operation: accept a write, then assert reset before the next edge -> wr_enable=0 immediately; no write appears; ptr=0, so with req_valid=4'b1010 after reset, requester 1 wins.
- Saturation: with count_width=4, perform 17 valid writes -> write_count stops at 15.
